// File: rtl/taxi_axis_frame_gate_if.sv
// AXI4-Stream interface bundle with per-sideband enables; the widths and enables travel
// with the interface so that blocks can read them.
interface taxi_axis_if #(
  parameter int unsigned DATA_W  = 8,
  parameter bit          KEEP_EN = (DATA_W > 8),
  parameter int unsigned KEEP_W  = (DATA_W + 7) / 8,
  parameter bit          STRB_EN = 1'b0,
  parameter bit          LAST_EN = 1'b1,
  parameter bit          ID_EN   = 1'b0,
  parameter int unsigned ID_W    = 8,
  parameter bit          DEST_EN = 1'b0,
  parameter int unsigned DEST_W  = 8,
  parameter bit          USER_EN = 1'b0,
  parameter int unsigned USER_W  = 1
);
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic [KEEP_W-1:0] tstrb;
  logic              tlast;
  logic [ID_W-1:0]   tid;
  logic [DEST_W-1:0] tdest;
  logic [USER_W-1:0] tuser;
  logic              tvalid;
  logic              tready;

  modport src (
    output tdata, tkeep, tstrb, tlast, tid, tdest, tuser, tvalid,
    input  tready
  );

  modport snk (
    input  tdata, tkeep, tstrb, tlast, tid, tdest, tuser, tvalid,
    output tready
  );
endinterface

// File: rtl/taxi_axis_frame_gate.sv
// Frame-granular stream gate: the enable level seen on a frame's first beat decides whether
// the whole frame is forwarded through a two-entry skid buffer or silently consumed.
module taxi_axis_frame_gate #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  taxi_axis_if.snk         s_axis,
  taxi_axis_if.src         m_axis,
  input  logic             enable,
  output logic [CNT_W-1:0] stat_pass_frames,
  output logic [CNT_W-1:0] stat_drop_frames,
  output logic             stat_drop
);
  localparam int unsigned DATA_W  = s_axis.DATA_W;
  localparam bit          KEEP_EN = s_axis.KEEP_EN && m_axis.KEEP_EN;
  localparam int unsigned KEEP_W  = m_axis.KEEP_W;
  localparam bit          STRB_EN = s_axis.STRB_EN && m_axis.STRB_EN;
  localparam bit          LAST_EN = s_axis.LAST_EN && m_axis.LAST_EN;
  localparam bit          ID_EN   = s_axis.ID_EN && m_axis.ID_EN;
  localparam int unsigned ID_W    = m_axis.ID_W;
  localparam bit          DEST_EN = s_axis.DEST_EN && m_axis.DEST_EN;
  localparam int unsigned DEST_W  = m_axis.DEST_W;
  localparam bit          USER_EN = s_axis.USER_EN && m_axis.USER_EN;
  localparam int unsigned USER_W  = m_axis.USER_W;

  if (m_axis.DATA_W != DATA_W) begin : g_err_data_w
    $fatal(1, "taxi_axis_frame_gate: m_axis DATA_W differs from s_axis DATA_W");
  end
  if (KEEP_EN && (s_axis.KEEP_W != m_axis.KEEP_W)) begin : g_err_keep_w
    $fatal(1, "taxi_axis_frame_gate: m_axis KEEP_W differs from s_axis KEEP_W");
  end

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic [KEEP_W-1:0] strb;
    logic              last;
    logic [ID_W-1:0]   id;
    logic [DEST_W-1:0] dest;
    logic [USER_W-1:0] user;
  } beat_t;

  typedef enum logic [1:0] {StIdle, StPass, StDrop} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] pass_cnt_q, drop_cnt_q;
  logic             drop_pulse_q;

  logic  s_ready_q, s_ready_d;
  logic  m_valid_q, m_valid_d;
  logic  tmp_valid_q, tmp_valid_d;
  beat_t out_q, tmp_q, in_beat;
  logic  load_out_in, load_out_tmp, load_tmp_in;

  logic in_last, accept, sel_pass, pass_beat;

  // Disabled sidebands are normalised on entry so the registers already hold the constants.
  always_comb begin
    in_beat.data = s_axis.tdata;
    in_beat.keep = KEEP_EN ? KEEP_W'(s_axis.tkeep) : '1;
    in_beat.strb = STRB_EN ? KEEP_W'(s_axis.tstrb) : in_beat.keep;
    in_beat.last = in_last;
    in_beat.id   = ID_EN ? ID_W'(s_axis.tid) : '0;
    in_beat.dest = DEST_EN ? DEST_W'(s_axis.tdest) : '0;
    in_beat.user = USER_EN ? USER_W'(s_axis.tuser) : '0;
  end

  assign in_last   = LAST_EN ? s_axis.tlast : 1'b1;
  assign accept    = s_axis.tvalid && s_ready_q;
  assign sel_pass  = (state_q == StIdle) ? enable : (state_q == StPass);
  assign pass_beat = accept && sel_pass;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      pass_cnt_q   <= '0;
      drop_cnt_q   <= '0;
      drop_pulse_q <= 1'b0;
    end else begin
      drop_pulse_q <= 1'b0;
      if (accept) begin
        if (in_last) begin
          state_q <= StIdle;
          if (sel_pass) begin
            pass_cnt_q <= pass_cnt_q + CNT_W'(1);
          end else begin
            drop_cnt_q   <= drop_cnt_q + CNT_W'(1);
            drop_pulse_q <= 1'b1;
          end
        end else if (state_q == StIdle) begin
          state_q <= sel_pass ? StPass : StDrop;
        end
      end
    end
  end

  // A registered ready only ever admits a beat while the temp slot is empty.
  always_comb begin
    m_valid_d    = m_valid_q;
    tmp_valid_d  = tmp_valid_q;
    load_out_in  = 1'b0;
    load_out_tmp = 1'b0;
    load_tmp_in  = 1'b0;
    if (s_ready_q) begin
      if (m_axis.tready || !m_valid_q) begin
        m_valid_d   = pass_beat;
        load_out_in = pass_beat;
      end else begin
        tmp_valid_d = pass_beat;
        load_tmp_in = pass_beat;
      end
    end else if (m_axis.tready) begin
      m_valid_d    = tmp_valid_q;
      tmp_valid_d  = 1'b0;
      load_out_tmp = 1'b1;
    end
    s_ready_d = m_axis.tready || !m_valid_q || (!tmp_valid_q && !pass_beat);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_ready_q   <= 1'b0;
      m_valid_q   <= 1'b0;
      tmp_valid_q <= 1'b0;
    end else begin
      s_ready_q   <= s_ready_d;
      m_valid_q   <= m_valid_d;
      tmp_valid_q <= tmp_valid_d;
    end
    if (load_out_in) begin
      out_q <= in_beat;
    end else if (load_out_tmp) begin
      out_q <= tmp_q;
    end
    if (load_tmp_in) begin
      tmp_q <= in_beat;
    end
  end

  assign s_axis.tready    = s_ready_q;
  assign m_axis.tvalid    = m_valid_q;
  assign m_axis.tdata     = out_q.data;
  assign m_axis.tkeep     = out_q.keep;
  assign m_axis.tstrb     = out_q.strb;
  assign m_axis.tlast     = out_q.last;
  assign m_axis.tid       = out_q.id;
  assign m_axis.tdest     = out_q.dest;
  assign m_axis.tuser     = out_q.user;
  assign stat_pass_frames = pass_cnt_q;
  assign stat_drop_frames = drop_cnt_q;
  assign stat_drop        = drop_pulse_q;
endmodule

// File: tb/tb_taxi_axis_frame_gate.sv
// Bench for taxi_axis_frame_gate: directed scenarios plus randomized frames, all checked
// against a frame-level scoreboard model.
`timescale 1ns/1ps
module tb_taxi_axis_frame_gate;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  taxi_axis_if #(.DATA_W(32), .KEEP_EN(1), .KEEP_W(4), .STRB_EN(0), .LAST_EN(1), .ID_EN(1),
    .ID_W(4), .DEST_EN(0), .DEST_W(3), .USER_EN(1), .USER_W(2)) sa ();
  taxi_axis_if #(.DATA_W(32), .KEEP_EN(1), .KEEP_W(4), .STRB_EN(0), .LAST_EN(1), .ID_EN(1),
    .ID_W(4), .DEST_EN(0), .DEST_W(3), .USER_EN(1), .USER_W(2)) ma ();
  taxi_axis_if #(.DATA_W(32), .LAST_EN(0)) sbi ();
  taxi_axis_if #(.DATA_W(32), .LAST_EN(0)) mbi ();

  logic        en_a = 1'b0, en_b = 1'b0;
  logic [7:0]  a_pass, a_drop;
  logic [15:0] b_pass, b_drop;
  logic        a_sdrop, b_sdrop;

  taxi_axis_frame_gate #(.CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .s_axis(sa), .m_axis(ma), .enable(en_a),
    .stat_pass_frames(a_pass), .stat_drop_frames(a_drop), .stat_drop(a_sdrop)
  );
  taxi_axis_frame_gate #(.CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .s_axis(sbi), .m_axis(mbi), .enable(en_b),
    .stat_pass_frames(b_pass), .stat_drop_frames(b_drop), .stat_drop(b_sdrop)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: each accepted beat either opens a frame (taking enable) or continues one.
  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic [3:0]  id;
    logic [1:0]  user;
  } beat_t;

  beat_t       scb[$];
  logic        in_frame = 1'b0, frame_pass = 1'b0;
  logic [7:0]  exp_pass = '0, exp_drop = '0;
  logic        exp_sdrop = 1'b0;
  int          cyc = 0, out_cnt = 0, drop_pulses = 0, tvalid_cycles = 0;
  bit          lat_mode = 1'b0, saw_ready_low = 1'b0, stall_q = 1'b0;
  logic [31:0] stall_data = '0;

  always @(negedge clk) begin
    beat_t b;
    cyc++;
    if (rst) begin
      scb.delete();
      in_frame  = 1'b0;
      exp_pass  = '0;
      exp_drop  = '0;
      exp_sdrop = 1'b0;
      stall_q   = 1'b0;
    end else begin
      check_eq("pass_frames", a_pass, exp_pass);
      check_eq("drop_frames", a_drop, exp_drop);
      check_eq("stat_drop", a_sdrop, exp_sdrop);
      if (a_sdrop) drop_pulses++;
      exp_sdrop = 1'b0;
      if (stall_q) begin
        check_eq("stall_valid", ma.tvalid, 1);
        check_eq("stall_data", ma.tdata, stall_data);
      end
      if (ma.tvalid) tvalid_cycles++;
      if (!sa.tready) saw_ready_low = 1'b1;
      if (ma.tvalid && ma.tready) begin
        check_eq("beat_expected", scb.size() != 0, 1);
        if (scb.size() != 0) begin
          b = scb.pop_front();
          check_eq("tdata", ma.tdata, b.data);
          check_eq("tkeep", ma.tkeep, b.keep);
          check_eq("tstrb", ma.tstrb, b.keep);
          check_eq("tlast", ma.tlast, b.last);
          check_eq("tid", ma.tid, b.id);
          check_eq("tdest", ma.tdest, 0);
          check_eq("tuser", ma.tuser, b.user);
          if (lat_mode) check_eq("latency", cyc - b.cyc, 1);
          out_cnt++;
        end
      end
      stall_q    = ma.tvalid && !ma.tready;
      stall_data = ma.tdata;
      if (sa.tvalid && sa.tready) begin
        if (!in_frame) frame_pass = en_a;
        if (frame_pass) scb.push_back({32'(cyc), sa.tdata, sa.tkeep, sa.tlast, sa.tid, sa.tuser});
        if (sa.tlast) begin
          in_frame = 1'b0;
          if (frame_pass) exp_pass++;
          else begin
            exp_drop++;
            exp_sdrop = 1'b1;
          end
        end else begin
          in_frame = 1'b1;
        end
      end
      check_eq("occupancy", scb.size() <= 2, 1);
    end
  end

  logic [31:0] b_out[$];
  always @(negedge clk) begin
    if (!rst && mbi.tvalid && mbi.tready) begin
      b_out.push_back(mbi.tdata);
      check_eq("b_tlast", mbi.tlast, 1);
    end
  end

  // m_axis.tready source: 0 = held high, 1 = random, 2 = repeating 1,0,0,1
  int         tr_mode = 0;
  logic [3:0] pat = 4'b1001;
  initial begin
    int pidx = 0;
    ma.tready  = 1'b1;
    mbi.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (tr_mode)
        1:       ma.tready = 1'($urandom_range(0, 1));
        2: begin
          ma.tready = pat[pidx];
          pidx = (pidx + 1) % 4;
        end
        default: ma.tready = 1'b1;
      endcase
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_a(input logic [31:0] d, input logic last, input logic en, output int t);
    t = 0;
    sa.tvalid = 1'b1;
    sa.tdata  = d;
    sa.tlast  = last;
    sa.tkeep  = 4'($urandom);
    sa.tstrb  = 4'($urandom);
    sa.tid    = 4'($urandom);
    sa.tdest  = 3'($urandom);
    sa.tuser  = 2'($urandom);
    en_a      = en;
    do begin
      @(negedge clk);
      t++;
    end while (!(sa.tvalid && sa.tready) && t < 200);
    check_eq("a_accept_bound", t < 200, 1);
    @(posedge clk);
    #1;
    sa.tvalid = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] d, input logic en);
    int t = 0;
    sbi.tvalid = 1'b1;
    sbi.tdata  = d;
    sbi.tlast  = 1'b0;
    en_b       = en;
    do begin
      @(negedge clk);
      t++;
    end while (!(sbi.tvalid && sbi.tready) && t < 200);
    check_eq("b_accept_bound", t < 200, 1);
    @(posedge clk);
    #1;
    sbi.tvalid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, base, tv0, dp0;
    logic [31:0] dv[6];
    {sa.tvalid, sa.tdata, sa.tkeep, sa.tstrb, sa.tlast, sa.tid, sa.tdest, sa.tuser} = '0;
    {sbi.tvalid, sbi.tdata, sbi.tkeep, sbi.tstrb, sbi.tlast, sbi.tid, sbi.tdest, sbi.tuser} = '0;
    rst = 1'b1;
    idle(2);
    @(negedge clk);
    check_eq("rst_s_tready", sa.tready, 0);
    check_eq("rst_m_tvalid", ma.tvalid, 0);
    check_eq("rst_pass", a_pass, 0);
    check_eq("rst_drop", a_drop, 0);
    check_eq("rst_stat_drop", a_sdrop, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("tready_first_cycle", sa.tready, 0);
    @(negedge clk);
    check_eq("tready_rise", sa.tready, 1);
    idle(1);

    // Three 4-beat passing frames, sink always ready
    lat_mode = 1'b1;
    base = out_cnt;
    for (int f = 0; f < 3; f++)
      for (int b = 0; b < 4; b++) send_a($urandom, b == 3, 1'b1, w);
    idle(3);
    lat_mode = 1'b0;
    check_eq("t1_out_beats", out_cnt - base, 12);
    check_eq("t1_pass", a_pass, 3);
    check_eq("t1_drop", a_drop, 0);

    // One dropped 5-beat frame
    tv0 = tvalid_cycles;
    dp0 = drop_pulses;
    for (int b = 0; b < 5; b++) begin
      send_a($urandom, b == 4, 1'b0, w);
      check_eq("t2_s_tready_high", w, 1);
    end
    idle(3);
    check_eq("t2_m_tvalid_cycles", tvalid_cycles - tv0, 0);
    check_eq("t2_drop_pulses", drop_pulses - dp0, 1);
    check_eq("t2_drop", a_drop, 1);

    // enable falls on beat 2 mid-frame, next frame dropped
    base = out_cnt;
    for (int b = 0; b < 4; b++) send_a($urandom, b == 3, b == 0, w);
    for (int b = 0; b < 3; b++) send_a($urandom, b == 2, 1'b0, w);
    idle(3);
    check_eq("t3_out_beats", out_cnt - base, 4);
    check_eq("t3_pass", a_pass, 4);
    check_eq("t3_drop", a_drop, 2);

    // Sink stalls with tready pattern 1,0,0,1
    tr_mode = 2;
    saw_ready_low = 1'b0;
    base = out_cnt;
    for (int b = 0; b < 8; b++) send_a($urandom, b % 4 == 3, 1'b1, w);
    idle(8);
    tr_mode = 0;
    idle(3);
    check_eq("t4_out_beats", out_cnt - base, 8);
    check_eq("t4_ready_low_in_stall", saw_ready_low, 1);
    check_eq("t4_pass", a_pass, 6);

    // Randomized frames, gaps, per-beat enable and backpressure
    tr_mode = 1;
    for (int f = 0; f < 400; f++) begin
      int len = $urandom_range(1, 5);
      for (int b = 0; b < len; b++) begin
        send_a($urandom, b == len - 1, 1'($urandom_range(0, 1)), w);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
    end
    tr_mode = 0;
    idle(10);
    check_eq("rand_drained", scb.size(), 0);

    // Reset during beat 2 of a passing frame
    send_a($urandom, 1'b0, 1'b1, w);
    send_a($urandom, 1'b0, 1'b1, w);
    sa.tvalid = 1'b1;
    sa.tdata  = $urandom;
    sa.tlast  = 1'b0;
    en_a      = 1'b1;
    rst       = 1'b1;
    idle(1);
    @(negedge clk);
    check_eq("t6_rst_s_tready", sa.tready, 0);
    check_eq("t6_rst_m_tvalid", ma.tvalid, 0);
    check_eq("t6_rst_pass", a_pass, 0);
    check_eq("t6_rst_drop", a_drop, 0);
    check_eq("t6_rst_stat_drop", a_sdrop, 0);
    sa.tvalid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("t6_tready_first_cycle", sa.tready, 0);
    base = out_cnt;
    idle(1);
    send_a($urandom, 1'b1, 1'b0, w);
    idle(3);
    check_eq("t6_drop", a_drop, 1);
    check_eq("t6_pass", a_pass, 0);
    check_eq("t6_out_beats", out_cnt - base, 0);

    // Without tlast each beat is its own frame
    b_out.delete();
    for (int i = 0; i < 6; i++) begin
      dv[i] = $urandom;
      send_b(dv[i], i % 2 == 0);
    end
    idle(3);
    check_eq("t5_out_beats", b_out.size(), 3);
    if (b_out.size() == 3) begin
      check_eq("t5_beat0", b_out[0], dv[0]);
      check_eq("t5_beat2", b_out[1], dv[2]);
      check_eq("t5_beat4", b_out[2], dv[4]);
    end
    check_eq("t5_pass", b_pass, 3);
    check_eq("t5_drop", b_drop, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/taxi_axis_frame_gate.md
TAXI_AXIS_FRAME_GATE -- requirements
Module: taxi_axis_frame_gate

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the frame statistics counters.
REQ-002 SHALL take all stream widths and sideband enables (DATA_W, KEEP_EN/KEEP_W, STRB_EN, LAST_EN, ID_EN/ID_W, DEST_EN/DEST_W, USER_EN/USER_W) from the interfaces. Each sideband enable is the AND of the s_axis and m_axis settings.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 s_axis  taxi_axis_if.snk  DATA_W+sideband  stream input, typically one output of the broadcaster.
REQ-006 m_axis  taxi_axis_if.src  DATA_W+sideband  gated stream output.
REQ-007 enable  input  1  pass (1) or drop (0) request, sampled only at frame start.
REQ-008 stat_pass_frames  output  CNT_W  count of frames forwarded.
REQ-009 stat_drop_frames  output  CNT_W  count of frames discarded.
REQ-010 stat_drop  output  1  one-cycle pulse when a dropped frame's last beat is consumed.
REQ-011 SHALL report a fatal elaboration error if the m_axis DATA_W differs from s_axis, or if KEEP_EN is set and KEEP_W differs.

Function
REQ-012 Frame: beats up to and including tlast=1. With LAST_EN=0, every beat is a one-beat frame.
REQ-013 FSM states: IDLE (next accepted beat starts a frame), PASS, DROP.
REQ-014 IDLE, beat accepted: enable=1 selects PASS, enable=0 selects DROP. If that beat has tlast=1, the frame completes immediately and the FSM stays in IDLE.
REQ-015 PASS/DROP, beat accepted with tlast=1: return to IDLE. Otherwise hold state. enable is ignored mid-frame.
REQ-016 Accepted beat = s_axis.tvalid && s_axis.tready in the same cycle.
REQ-017 PASS beats (including the first beat when it selects PASS) go through a two-entry skid buffer: output register plus temp register.
REQ-018 DROP beats are consumed and never written to any register.
REQ-019 s_axis.tready SHALL be registered. It is high in cycle N+1 if the output register is empty or being drained in cycle N, or if the temp register is empty and no valid input is pending.
REQ-020 Latency: a passed beat accepted in cycle N is presented on m_axis in cycle N+1 when the output register is free.
REQ-021 Throughput: one beat per cycle sustained with m_axis.tready held at 1.
REQ-022 m_axis.tvalid deasserts after a handshake unless new data is loaded.
REQ-023 Beat order is preserved; temp data moves to output before newer input.
REQ-024 Payload is forwarded bit-exact. Disabled sidebands are driven to constants: tkeep all ones, tstrb = tkeep, tlast 1, tid/tdest/tuser 0.
REQ-025 stat_pass_frames increments by 1 on the accepted tlast beat of a PASS frame, including a one-beat frame selected for PASS.
REQ-026 stat_drop_frames and stat_drop behave the same way for DROP frames. Both counters wrap modulo 2^CNT_W.
REQ-027 Backpressure never drops or duplicates a beat. An m_axis stall with tready low holds tdata and tvalid stable.

Reset
REQ-028 On rst: FSM to IDLE; s_axis.tready=0, m_axis.tvalid=0, temp valid=0, stat_drop=0, both counters=0.
REQ-029 The first cycle after reset release SHALL have tready=0; tready rises one cycle later.
REQ-030 rst mid-frame SHALL abandon the frame. The next accepted beat after reset is treated as a frame start.
REQ-031 Data registers need not be reset.

Verification
REQ-032 enable=1, 3 frames of 4 beats, m tready=1 -> 12 beats out in order, one cycle latency, stat_pass_frames=3, stat_drop_frames=0.
REQ-033 enable=0, frame of 5 beats -> m tvalid never high, s tready stays high, stat_drop pulses once on beat 5, stat_drop_frames=1.
REQ-034 enable toggles 1->0 on beat 2 of a 4-beat frame -> all 4 beats forwarded; next frame with enable=0 dropped.
REQ-035 m tready pattern 1,0,0,1 with continuous input -> at most 2 beats buffered, s tready low during stall, no loss or reorder, data stable while stalled.
REQ-036 LAST_EN=0, alternating enable per beat, 6 beats -> beats 0,2,4 forwarded, stat_pass_frames=3, stat_drop_frames=3.
REQ-037 rst asserted during beat 2 of a passing frame -> outputs return to reset values, counters 0, next beat after release opens a new frame using enable.
